// File: rtl/wavelet_frame_ctrl.sv
// wavelet_frame_ctrl: streams a sample frame into db_wavelet, flushes it, stores results.
// Define PEAK_TRACK_EN to add peak_val_o/peak_idx_o (max captured result and its index).
module wavelet_frame_ctrl #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] frame_len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] out_count_o,
  output logic              overflow_o,
  output logic              smp_rd_o,
  output logic [ADDR_W-1:0] smp_addr_o,
  input  logic [DATA_W-1:0] smp_data_i,
  output logic              wav_rst_o,
  output logic [DATA_W-1:0] wav_data_o,
  input  logic [DATA_W-1:0] wav_abs_i,
  input  logic              wav_we_i,
  output logic              res_we_o,
  output logic [ADDR_W-1:0] res_addr_o,
  output logic [DATA_W-1:0] res_data_o
`ifdef PEAK_TRACK_EN
  ,
  output logic [DATA_W-1:0] peak_val_o,
  output logic [ADDR_W-1:0] peak_idx_o
`endif
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FL_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] MAXC = '1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] FEED  = 3'd2;
  localparam logic [2:0] FLUSH = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [FW-1:0]     fl_q, fl_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              abrt_q, abrt_d;
  logic              vld_q, vld_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              cap;
`ifdef PEAK_TRACK_EN
  logic [DATA_W-1:0] pk_val_q, pk_val_d;
  logic [ADDR_W-1:0] pk_idx_q, pk_idx_d;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rd_d    = rd_q;
    fl_d    = fl_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    abrt_d  = 1'b0;
    vld_d   = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef PEAK_TRACK_EN
    pk_val_d = pk_val_q;
    pk_idx_d = pk_idx_q;
`endif
    cap = wav_we_i && !abort_i
       && (state_q == FEED || state_q == FLUSH);
    // A full result RAM drops the result and latches overflow
    if (cap) begin
      if (cnt_q == MAXC) begin
        ovf_d = 1'b1;
      end else begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        data_d = wav_abs_i;
        cnt_d  = cnt_q + ONE;
`ifdef PEAK_TRACK_EN
        if (wav_abs_i > pk_val_q) begin
          pk_val_d = wav_abs_i;
          pk_idx_d = cnt_q;
        end
`endif
      end
    end
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          len_d = frame_len_i;
          rd_d  = '0;
          fl_d  = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
`ifdef PEAK_TRACK_EN
          pk_val_d = '0;
          pk_idx_d = '0;
`endif
          state_d = (frame_len_i != '0) ? CLEAR : DONE;
        end
      end
      CLEAR: state_d = FEED;
      FEED: begin
        vld_d = 1'b1;
        if (rd_q == len_q - ONE) state_d = FLUSH;
        else rd_d = rd_q + ONE;
      end
      FLUSH: begin
        if (fl_q == FL_LAST) state_d = DONE;
        else fl_d = fl_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      abrt_d  = 1'b1;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      len_q   <= '0;
      rd_q    <= '0;
      fl_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      abrt_q  <= 1'b0;
      vld_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef PEAK_TRACK_EN
      pk_val_q <= '0;
      pk_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
      fl_q    <= fl_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      abrt_q  <= abrt_d;
      vld_q   <= vld_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef PEAK_TRACK_EN
      pk_val_q <= pk_val_d;
      pk_idx_q <= pk_idx_d;
`endif
    end
  end

  assign busy_o      = (state_q == CLEAR) || (state_q == FEED)
                    || (state_q == FLUSH);
  assign done_o      = (state_q == DONE);
  assign out_count_o = cnt_q;
  assign overflow_o  = ovf_q;
  assign smp_rd_o    = (state_q == FEED);
  assign smp_addr_o  = (state_q == FEED) ? rd_q : '0;
  assign wav_rst_o   = (state_q == CLEAR) || abrt_q;
  // Sample RAM has one cycle of read latency; gate so flush feeds zeros
  assign wav_data_o  = vld_q ? smp_data_i : '0;
  assign res_we_o    = we_q;
  assign res_addr_o  = addr_q;
  assign res_data_o  = data_q;
`ifdef PEAK_TRACK_EN
  assign peak_val_o  = pk_val_q;
  assign peak_idx_o  = pk_idx_q;
`endif

endmodule
